// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_if
//  Description : Bus bundle between the SAP control sequencer and the
//                datapath.
//                Sequencer inputs  : SLOW_CLOCK_STRB, HALT, STEP_MODE, STEP,
//                                    INSTR, condition_flags
//                Sequencer outputs : pc_out, pc_count, ram_in, ram_out,
//                                    ram_wr, ir_in, ir_out, out_in, alu_en,
//                                    branch, reg_in/reg_out/reg_mov (one-hot),
//                                    alu_sel
//                modport master = sequencer side, modport slave = datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_sequencer_if #(
   parameter int NUM_REGS = 4
) ();
   localparam int RSW = $clog2(NUM_REGS);
   localparam int IW  = 8 + 2 * RSW;

   logic                SLOW_CLOCK_STRB;
   logic                HALT;
   logic                STEP_MODE;
   logic                STEP;
   logic [IW-1:0]       INSTR;
   logic [3:0]          condition_flags;

   logic                pc_out;
   logic                pc_count;
   logic                ram_in;
   logic                ram_out;
   logic                ram_wr;
   logic                ir_in;
   logic                ir_out;
   logic                out_in;
   logic                alu_en;
   logic                branch;
   logic [NUM_REGS-1:0] reg_in;
   logic [NUM_REGS-1:0] reg_out;
   logic [NUM_REGS-1:0] reg_mov;
   logic [6:0]          alu_sel;

   modport master (
      input  SLOW_CLOCK_STRB, HALT, STEP_MODE, STEP, INSTR, condition_flags,
      output pc_out, pc_count, ram_in, ram_out, ram_wr, ir_in, ir_out, out_in,
             alu_en, branch, reg_in, reg_out, reg_mov, alu_sel
   );

   modport slave (
      output SLOW_CLOCK_STRB, HALT, STEP_MODE, STEP, INSTR, condition_flags,
      input  pc_out, pc_count, ram_in, ram_out, ram_wr, ir_in, ir_out, out_in,
             alu_en, branch, reg_in, reg_out, reg_mov, alu_sel
   );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Strobe-gated control sequencer for the SAP CPU. Walks each
//                instruction through FETCH0/FETCH1/EXEC0[/EXEC1], drives the
//                bus enables combinationally from state and INSTR, halts only
//                at instruction boundaries, supports single-step, traps
//                illegal opcodes and counts retired instructions.
//  Ports       : CLK, ARST_L (async, active-low)
//                bus          - cpu_sequencer_if.master (strobe, halt, step,
//                               instruction, flags in; enables out)
//                halted       - high while in HALTED
//                illegal_op   - sticky illegal-class flag
//                instr_count  - retired-instruction counter (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
   parameter int NUM_REGS        = 4,
   parameter int SYNC_STAGES     = 3,
   parameter int CNT_W           = 16,
   parameter int HALT_ON_ILLEGAL = 1
) (
   input  wire logic           CLK,
   input  wire logic           ARST_L,
   cpu_sequencer_if.master     bus,
   output logic                halted,
   output logic                illegal_op,
   output logic [CNT_W-1:0]    instr_count
);
   localparam int   RSW      = $clog2(NUM_REGS);
   localparam int   IW       = 8 + 2 * RSW;
   localparam logic ILL_HALT = (HALT_ON_ILLEGAL != 0);

   typedef enum logic [2:0] {
      FETCH0   = 3'd0,
      FETCH1   = 3'd1,
      EXEC0    = 3'd2,
      EXEC1    = 3'd3,
      STEPWAIT = 3'd4,
      HALTED   = 3'd5
   } state_t;

   state_t               state;
   state_t               retire_state;
   logic [SYNC_STAGES-1:0] halt_sync;
   logic                 halt_synced;
   logic                 step_pending;
   logic                 illegal_halt;

   logic [3:0]           op_class;
   logic [3:0]           func;
   logic [RSW-1:0]       ra;
   logic [RSW-1:0]       rb;
   logic                 is_mem;
   logic                 is_alu;
   logic                 is_illegal;
   logic                 cond_met;
   logic                 last_step;

   assign op_class   = bus.INSTR[IW-1 -: 4];
   assign func       = bus.INSTR[IW-5 -: 4];
   assign ra         = bus.INSTR[2*RSW-1 -: RSW];
   assign rb         = bus.INSTR[RSW-1:0];

   assign is_mem     = (op_class == 4'h0) || (op_class == 4'h1);
   assign is_alu     = (op_class >= 4'h4) && (op_class <= 4'h9);
   assign is_illegal = (op_class == 4'h3) ||
                       ((op_class >= 4'hA) && (op_class <= 4'hD));
   assign last_step  = ((state == EXEC0) && !is_mem) || (state == EXEC1);
   assign halt_synced = halt_sync[SYNC_STAGES-1];

   function automatic logic [NUM_REGS-1:0] onehot(input logic [RSW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // Branch condition on {N,Z,C,V}
   always_comb begin
      cond_met = 1'b0;
      case (func)
         4'h0: cond_met = 1'b1;
         4'h1: cond_met = bus.condition_flags[2];
         4'h2: cond_met = !bus.condition_flags[2];
         4'h3: cond_met = bus.condition_flags[1];
         4'h4: cond_met = !bus.condition_flags[1];
         4'h5: cond_met = bus.condition_flags[3];
         4'h6: cond_met = !bus.condition_flags[3];
         4'h7: cond_met = bus.condition_flags[0];
         4'h8: cond_met = !bus.condition_flags[0];
         4'h9: cond_met = bus.condition_flags[1] && !bus.condition_flags[2];
         4'hA: cond_met = !bus.condition_flags[1] || bus.condition_flags[2];
         4'hB: cond_met = (bus.condition_flags[3] == bus.condition_flags[0]);
         4'hC: cond_met = (bus.condition_flags[3] != bus.condition_flags[0]);
         4'hD: cond_met = !bus.condition_flags[2] &&
                          (bus.condition_flags[3] == bus.condition_flags[0]);
         4'hE: cond_met = bus.condition_flags[2] ||
                          (bus.condition_flags[3] != bus.condition_flags[0]);
         default: cond_met = 1'b0;
      endcase
   end

   // Bus enables: combinational from state and INSTR
   always_comb begin
      bus.pc_out   = 1'b0;
      bus.pc_count = 1'b0;
      bus.ram_in   = 1'b0;
      bus.ram_out  = 1'b0;
      bus.ram_wr   = 1'b0;
      bus.ir_in    = 1'b0;
      bus.ir_out   = 1'b0;
      bus.out_in   = 1'b0;
      bus.alu_en   = 1'b0;
      bus.branch   = 1'b0;
      bus.reg_in   = '0;
      bus.reg_out  = '0;
      bus.reg_mov  = '0;
      bus.alu_sel  = '0;
      case (state)
         FETCH0: begin
            bus.pc_out = 1'b1;
            bus.ram_in = 1'b1;
         end
         FETCH1: begin
            bus.ram_out  = 1'b1;
            bus.ir_in    = 1'b1;
            bus.pc_count = 1'b1;
         end
         EXEC0: begin
            if (is_mem) begin
               bus.reg_out = onehot(rb);
               bus.ram_in  = 1'b1;
            end else if (op_class == 4'h2) begin
               bus.ir_out  = 1'b1;
               bus.reg_mov = onehot(ra);
            end else if (is_alu) begin
               bus.alu_en  = 1'b1;
               bus.reg_in  = onehot(ra);
               // Low three class bits minus 4 (mod 8) maps 4..9 onto 0..5
               bus.alu_sel = {op_class[2:0] - 3'd4, func};
            end else if (op_class == 4'hE) begin
               bus.branch  = cond_met;
               bus.ir_out  = cond_met;
            end else if (op_class == 4'hF) begin
               bus.reg_out = onehot(ra);
               bus.out_in  = 1'b1;
            end
         end
         EXEC1: begin
            if (op_class == 4'h0) begin
               bus.ram_out = 1'b1;
               bus.reg_in  = onehot(ra);
            end else begin
               bus.ram_wr  = 1'b1;
               bus.reg_out = onehot(ra);
            end
         end
         default: ;
      endcase
   end

   // Where to go after the last exec step of an instruction
   always_comb begin
      retire_state = FETCH0;
      if (is_illegal && ILL_HALT)
         retire_state = HALTED;
      else if (halt_synced)
         retire_state = HALTED;
      else if (bus.STEP_MODE)
         retire_state = STEPWAIT;
   end

   // HALT synchroniser runs on every CLK, independent of the strobe
   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L)
         halt_sync <= '0;
      else
         halt_sync <= {halt_sync[SYNC_STAGES-2:0], bus.HALT};
   end

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) begin
         state        <= FETCH0;
         halted       <= 1'b0;
         illegal_op   <= 1'b0;
         illegal_halt <= 1'b0;
         step_pending <= 1'b0;
         instr_count  <= '0;
      end else begin
         // A step request is only remembered while waiting for it
         if (state == STEPWAIT) begin
            if (bus.STEP)
               step_pending <= 1'b1;
         end else begin
            step_pending <= 1'b0;
         end

         if (bus.SLOW_CLOCK_STRB) begin
            if (last_step) begin
               instr_count  <= instr_count + 1'b1;
               illegal_op   <= illegal_op | is_illegal;
               illegal_halt <= illegal_halt | (is_illegal & ILL_HALT);
               state        <= retire_state;
               halted       <= (retire_state == HALTED);
            end else begin
               case (state)
                  FETCH0: state <= FETCH1;
                  FETCH1: state <= EXEC0;
                  EXEC0:  state <= EXEC1;
                  STEPWAIT: begin
                     if (halt_synced) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                     end else if (step_pending || !bus.STEP_MODE) begin
                        state        <= FETCH0;
                        step_pending <= 1'b0;
                     end
                  end
                  HALTED: begin
                     if (!halt_synced && !illegal_halt) begin
                        state  <= FETCH0;
                        halted <= 1'b0;
                     end
                  end
                  default: state <= FETCH0;
               endcase
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Self-checking bench for cpu_sequencer. Two instances share
//                stimulus: dut1 (CNT_W=16, illegal halts) and dut2 (CNT_W=4,
//                illegal treated as NOP). Expected enables come from a
//                per-instruction step table derived from the ISA rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;
   typedef struct packed {
      logic       pc_out, pc_count, ram_in, ram_out, ram_wr, ir_in, ir_out,
                  out_in, alu_en, branch;
      logic [3:0] reg_in, reg_out, reg_mov;
      logic [6:0] alu_sel;
   } ctrl_t;

   logic        CLK = 1'b0;
   logic        ARST_L = 1'b0;
   logic        strb = 1'b0, halt = 1'b0, step_mode = 1'b0, step = 1'b0;
   logic [11:0] instr = '0;
   logic [3:0]  flags = '0;

   logic        halted1, illegal1, halted2, illegal2;
   logic [15:0] cnt1;
   logic [3:0]  cnt2;

   int passes = 0;
   int checks = 0;
   int exp_cnt = 0;
   int legal[11] = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 14, 15};

   always #5 CLK = ~CLK;

   cpu_sequencer_if #(.NUM_REGS(4)) bus1 ();
   cpu_sequencer_if #(.NUM_REGS(4)) bus2 ();

   assign bus1.SLOW_CLOCK_STRB = strb;
   assign bus1.HALT            = halt;
   assign bus1.STEP_MODE       = step_mode;
   assign bus1.STEP            = step;
   assign bus1.INSTR           = instr;
   assign bus1.condition_flags = flags;
   assign bus2.SLOW_CLOCK_STRB = strb;
   assign bus2.HALT            = halt;
   assign bus2.STEP_MODE       = step_mode;
   assign bus2.STEP            = step;
   assign bus2.INSTR           = instr;
   assign bus2.condition_flags = flags;

   cpu_sequencer #(.NUM_REGS(4), .SYNC_STAGES(3), .CNT_W(16), .HALT_ON_ILLEGAL(1)) dut1 (
      .CLK(CLK), .ARST_L(ARST_L), .bus(bus1),
      .halted(halted1), .illegal_op(illegal1), .instr_count(cnt1));

   cpu_sequencer #(.NUM_REGS(4), .SYNC_STAGES(3), .CNT_W(4), .HALT_ON_ILLEGAL(0)) dut2 (
      .CLK(CLK), .ARST_L(ARST_L), .bus(bus2),
      .halted(halted2), .illegal_op(illegal2), .instr_count(cnt2));

   ctrl_t act1, act2;
   assign act1 = {bus1.pc_out, bus1.pc_count, bus1.ram_in, bus1.ram_out, bus1.ram_wr,
                  bus1.ir_in, bus1.ir_out, bus1.out_in, bus1.alu_en, bus1.branch,
                  bus1.reg_in, bus1.reg_out, bus1.reg_mov, bus1.alu_sel};
   assign act2 = {bus2.pc_out, bus2.pc_count, bus2.ram_in, bus2.ram_out, bus2.ram_wr,
                  bus2.ir_in, bus2.ir_out, bus2.out_in, bus2.alu_en, bus2.branch,
                  bus2.reg_in, bus2.reg_out, bus2.reg_mov, bus2.alu_sel};

   // ---------------- reference model ----------------
   function automatic logic cond_of(input int fn, input logic [3:0] fl);
      logic n, z, c, v;
      {n, z, c, v} = fl;
      case (fn)
         0:  return 1'b1;
         1:  return z;
         2:  return !z;
         3:  return c;
         4:  return !c;
         5:  return n;
         6:  return !n;
         7:  return v;
         8:  return !v;
         9:  return c && !z;
         10: return !c || z;
         11: return n == v;
         12: return n != v;
         13: return !z && (n == v);
         14: return z || (n != v);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int nsteps(input logic [11:0] ins);
      return (ins[11:8] <= 4'd1) ? 4 : 3;
   endfunction

   // Expected enables for step s (0 = FETCH0) of instruction ins
   function automatic ctrl_t model_ctrl(input logic [11:0] ins, input logic [3:0] fl,
                                        input int s);
      ctrl_t c;
      int cls, fn, ra, rb;
      c   = '0;
      cls = int'(ins[11:8]);
      fn  = int'(ins[7:4]);
      ra  = int'(ins[3:2]);
      rb  = int'(ins[1:0]);
      if (s == 0) begin
         c.pc_out = 1'b1; c.ram_in = 1'b1;
      end else if (s == 1) begin
         c.ram_out = 1'b1; c.ir_in = 1'b1; c.pc_count = 1'b1;
      end else if (s == 2) begin
         case (cls)
            0, 1: begin c.reg_out[rb] = 1'b1; c.ram_in = 1'b1; end
            2:    begin c.ir_out = 1'b1; c.reg_mov[ra] = 1'b1; end
            4, 5, 6, 7, 8, 9: begin
               c.alu_en = 1'b1; c.reg_in[ra] = 1'b1;
               c.alu_sel = 7'((cls - 4) * 16 + fn);
            end
            14: begin c.branch = cond_of(fn, fl); c.ir_out = cond_of(fn, fl); end
            15: begin c.reg_out[ra] = 1'b1; c.out_in = 1'b1; end
            default: ;
         endcase
      end else begin
         if (cls == 0) begin c.ram_out = 1'b1; c.reg_in[ra] = 1'b1; end
         else          begin c.ram_wr = 1'b1;  c.reg_out[ra] = 1'b1; end
      end
      return c;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_ctrl(input string tag, input ctrl_t e1, input ctrl_t e2);
      chk({tag, " dut1"}, 32'(act1), 32'(e1));
      chk({tag, " dut2"}, 32'(act2), 32'(e2));
   endtask

   task automatic chk_stat(input string tag, input logic h1, input logic i1,
                           input logic h2, input logic i2);
      chk({tag, " status"}, {28'd0, halted1, illegal1, halted2, illegal2},
          {28'd0, h1, i1, h2, i2});
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, " cnt16"}, {16'd0, cnt1}, 32'(exp_cnt & 16'hFFFF));
      chk({tag, " cnt4"},  {28'd0, cnt2}, 32'(exp_cnt % 16));
   endtask

   task automatic pulse();
      strb = 1'b1;
      @(negedge CLK);
      strb = 1'b0;
   endtask

   task automatic run_instr(input logic [11:0] ins, input logic [3:0] fl,
                            input int maxgap, input string tag);
      instr = ins;
      flags = fl;
      for (int s = 0; s < nsteps(ins); s++) begin
         repeat ($urandom_range(0, maxgap)) @(negedge CLK);
         chk_ctrl($sformatf("%s s%0d", tag, s), model_ctrl(ins, fl, s),
                  model_ctrl(ins, fl, s));
         pulse();
      end
      exp_cnt++;
      chk_cnt(tag);
   endtask

   localparam ctrl_t IDLE = '0;

   initial begin
      ctrl_t f0;
      logic [11:0] ins;
      f0 = model_ctrl(12'h000, 4'h0, 0);

      // Reset
      repeat (2) @(negedge CLK);
      chk_ctrl("reset", f0, f0);
      chk_stat("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("reset");
      ARST_L = 1'b1;
      @(negedge CLK);

      // Directed program: MOV r2, ADD r1, LDR r3<-[r0], branches
      run_instr({4'h2, 4'h0, 2'd2, 2'd0}, 4'h0, 2, "mov_r2");
      run_instr({4'h4, 4'h3, 2'd1, 2'd0}, 4'h0, 2, "add_r1");
      run_instr({4'h0, 4'h0, 2'd3, 2'd0}, 4'h0, 1, "ldr");
      run_instr({4'hE, 4'hD, 2'd0, 2'd0}, 4'b1001, 1, "bgt_taken");
      run_instr({4'hE, 4'hD, 2'd0, 2'd0}, 4'b1101, 1, "bgt_z");
      run_instr({4'hE, 4'hF, 2'd0, 2'd0}, 4'hF, 1, "bnever");

      // Random legal instructions
      for (int i = 0; i < 24; i++) begin
         ins = {4'(legal[$urandom_range(0, 10)]), 8'($urandom)};
         run_instr(ins, 4'($urandom), 3, $sformatf("rnd%0d", i));
      end

      // HALT raised during FETCH1 of a STR: STR completes, then HALTED
      ins = {4'h1, 4'h0, 2'd1, 2'd2};
      instr = ins; flags = 4'h0;
      chk_ctrl("str_halt s0", model_ctrl(ins, 4'h0, 0), model_ctrl(ins, 4'h0, 0));
      pulse();
      halt = 1'b1;
      chk_ctrl("str_halt s1", model_ctrl(ins, 4'h0, 1), model_ctrl(ins, 4'h0, 1));
      repeat (4) @(negedge CLK);
      pulse();
      chk_ctrl("str_halt s2", model_ctrl(ins, 4'h0, 2), model_ctrl(ins, 4'h0, 2));
      pulse();
      chk_ctrl("str_halt s3", model_ctrl(ins, 4'h0, 3), model_ctrl(ins, 4'h0, 3));
      pulse();
      exp_cnt++;
      chk_cnt("str_halt");
      chk_ctrl("halted idle", IDLE, IDLE);
      chk_stat("halted", 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (2) @(negedge CLK);
      pulse();
      chk_stat("halted stays", 1'b1, 1'b0, 1'b1, 1'b0);
      halt = 1'b0;
      pulse();
      chk_stat("release before sync", 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (4) @(negedge CLK);
      pulse();
      chk_ctrl("release fetch0", f0, f0);
      chk_stat("released", 1'b0, 1'b0, 1'b0, 1'b0);

      // HALT arriving too late for the sync: next instruction still runs
      ins = {4'h5, 4'h7, 2'd3, 2'd1};
      instr = ins;
      pulse();
      pulse();
      chk_ctrl("late_halt s2", model_ctrl(ins, 4'h0, 2), model_ctrl(ins, 4'h0, 2));
      halt = 1'b1;
      @(negedge CLK);
      pulse();
      exp_cnt++;
      chk_ctrl("late_halt fetch0", f0, f0);
      chk_stat("late_halt", 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr({4'hF, 4'h0, 2'd2, 2'd0}, 4'h0, 2, "after_late");
      chk_stat("late_halt halted", 1'b1, 1'b0, 1'b1, 1'b0);
      halt = 1'b0;
      repeat (4) @(negedge CLK);
      pulse();
      chk_ctrl("late_halt release", f0, f0);

      // Single-step mode
      step_mode = 1'b1;
      run_instr({4'hF, 4'h0, 2'd1, 2'd0}, 4'h0, 1, "step_out");
      chk_ctrl("stepwait", IDLE, IDLE);
      repeat (2) @(negedge CLK);
      pulse();
      chk_ctrl("stepwait hold", IDLE, IDLE);
      step = 1'b1;
      @(negedge CLK);
      step = 1'b0;
      repeat (2) @(negedge CLK);
      pulse();
      chk_ctrl("step go", f0, f0);
      run_instr({4'h0, 4'h2, 2'd2, 2'd3}, 4'h0, 1, "step_ldr");
      chk_ctrl("stepwait2", IDLE, IDLE);
      pulse();
      chk_ctrl("one step only", IDLE, IDLE);
      halt = 1'b1;
      step = 1'b1;
      @(negedge CLK);
      step = 1'b0;
      repeat (4) @(negedge CLK);
      pulse();
      chk_ctrl("step+halt idle", IDLE, IDLE);
      chk_stat("step+halt", 1'b1, 1'b0, 1'b1, 1'b0);
      halt = 1'b0;
      repeat (4) @(negedge CLK);
      pulse();
      chk_ctrl("step+halt release", f0, f0);
      run_instr({4'h2, 4'h1, 2'd0, 2'd0}, 4'h0, 1, "step_mov");
      chk_ctrl("stepwait3", IDLE, IDLE);
      step_mode = 1'b0;
      pulse();
      chk_ctrl("stepmode off", f0, f0);

      // Illegal class A: dut1 halts for good, dut2 carries on
      run_instr({4'hA, 4'h5, 2'd1, 2'd1}, 4'h0, 1, "illegal_a");
      chk_stat("illegal", 1'b1, 1'b1, 1'b0, 1'b1);
      chk_ctrl("illegal next", IDLE, f0);
      repeat (3) @(negedge CLK);
      pulse();
      pulse();
      chk_stat("illegal stuck", 1'b1, 1'b1, 1'b0, 1'b1);
      chk_ctrl("illegal stuck", IDLE, model_ctrl(12'hA51, 4'h0, 2));

      // Asynchronous reset mid-instruction
      #1;
      ARST_L = 1'b0;
      #1;
      exp_cnt = 0;
      chk_ctrl("areset", f0, f0);
      chk_stat("areset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("areset");
      @(negedge CLK);
      ARST_L = 1'b1;
      @(negedge CLK);
      run_instr({4'h9, 4'h2, 2'd3, 2'd2}, 4'h0, 1, "post_reset");
      run_instr({4'h3, 4'h0, 2'd0, 2'd0}, 4'h0, 1, "illegal_3");
      chk_stat("illegal_3", 1'b1, 1'b1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire
